// File: rtl/shumezuesi_16bit_pkg.sv
// Shared CPU constants for the execute-stage multiplier: the default operand
// width, the counter-width helper and the multiplier FSM state encoding.
package shumezuesi_16bit_pkg;

  localparam int WIDTH_DEF = 16;

  // The counter must be able to hold WIDTH itself, so it gets one bit more than log2.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/shumezuesi_16bit_if.sv
// Request/result bundle between the CPU control unit and the multiplier.
// The control unit is the master and the multiplier is the slave.
interface shumezuesi_16bit_if #(
  parameter int WIDTH = shumezuesi_16bit_pkg::WIDTH_DEF
);

  logic             Start;
  logic [WIDTH-1:0] Hyrja0;
  logic [WIDTH-1:0] Hyrja1;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] DaljaLo;
  logic [WIDTH-1:0] DaljaHi;

  modport master (
    output Start, Hyrja0, Hyrja1,
    input  Busy, Done, DaljaLo, DaljaHi
  );

  modport slave (
    input  Start, Hyrja0, Hyrja1,
    output Busy, Done, DaljaLo, DaljaHi
  );

endinterface

// File: rtl/shumezuesi_16bit_mbledhesi.sv
// WIDTH-bit unsigned adder with carry-out, used for the accumulate step of
// the shift-add multiplier.
module mbledhesi_16bit #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/shumezuesi_16bit.sv
// Sequential unsigned shift-add multiplier: retires one multiplier bit per clock.
// The product registers change only on entry to DONE.
module shumezuesi_16bit
  import shumezuesi_16bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                Clock,
  input  logic                Reset,
  shumezuesi_16bit_if.slave   bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t               state;
  state_t               state_nxt;
  logic                 accept;
  logic                 last_iter;
  logic [WIDTH-1:0]     mcand;
  logic [2*WIDTH:0]     acc;
  logic [2*WIDTH:0]     acc_step;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     sum;
  logic                 cout;

  mbledhesi_16bit #(.WIDTH(WIDTH)) u_mbledhesi (
    .a    (acc[2*WIDTH-1:WIDTH]),
    .b    (mcand),
    .sum  (sum),
    .cout (cout)
  );

  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  // The carry lands in the top accumulator bit before the shift brings it down.
  always_comb begin
    acc_step = acc >> 1;
    if (acc[0]) begin
      acc_step = {cout, sum, acc[WIDTH-1:0]} >> 1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values; blocking here would make results depend on statement order.
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.Start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        accept    = bus.Start;
        state_nxt = bus.Start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Start during RUN never reaches here: accept is only raised from IDLE or DONE.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      prod  <= '0;
    end else if (accept) begin
      mcand <= bus.Hyrja0;
      acc   <= {{(WIDTH + 1){1'b0}}, bus.Hyrja1};
      cnt   <= '0;
    end else if (state == RUN) begin
      acc <= acc_step;
      cnt <= cnt + CNT_W'(1);
      if (last_iter) begin
        prod <= acc_step[2*WIDTH-1:0];
      end
    end
  end

  assign bus.Busy    = (state == RUN);
  assign bus.Done    = (state == DONE);
  assign bus.DaljaLo = prod[WIDTH-1:0];
  assign bus.DaljaHi = prod[2*WIDTH-1:WIDTH];

endmodule

// File: tb/tb_shumezuesi_16bit.sv
// Self-checking bench for shumezuesi_16bit: a table of directed products,
// randomized products against an arithmetic model, and multi-cycle corner cases.
module tb_shumezuesi_16bit;

  logic Clock;
  logic Reset;

  shumezuesi_16bit_if #(.WIDTH(16)) bus ();

  shumezuesi_16bit dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  int          checks;
  int          errors;
  logic [31:0] last_prod;
  vec_t        vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  function automatic logic [31:0] outs();
    return {bus.DaljaHi, bus.DaljaLo};
  endfunction

  // Accepts a start with operands a*b and returns while Done is high.
  task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input string tag);
    logic [31:0] exp;
    int          edges;
    int          busy_cnt;
    bit          hold_ok;
    exp        = 32'(a) * 32'(b);
    bus.Hyrja0 = a;
    bus.Hyrja1 = b;
    bus.Start  = 1'b1;
    tick();
    bus.Start  = 1'b0;
    bus.Hyrja0 = 16'($urandom);
    bus.Hyrja1 = 16'($urandom);
    edges      = 1;
    busy_cnt   = 0;
    hold_ok    = 1'b1;
    while (!bus.Done && edges < 40) begin
      if (bus.Busy) busy_cnt++;
      if (outs() !== last_prod) hold_ok = 1'b0;
      tick();
      edges++;
    end
    check({tag, " latency"}, 32'(edges), 32'd17);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd16);
    check({tag, " hold_during_run"}, 32'(hold_ok), 32'd1);
    check({tag, " busy_with_done"}, 32'(bus.Busy), 32'd0);
    check({tag, " product"}, outs(), exp);
    last_prod = exp;
  endtask

  task automatic settle_idle(input string tag);
    tick();
    check({tag, " done_cleared"}, {30'd0, bus.Done, bus.Busy}, 32'd0);
    check({tag, " product_held"}, outs(), last_prod);
  endtask

  initial begin
    int          edges;
    int          dones;
    logic [15:0] ra;
    logic [15:0] rb;

    checks     = 0;
    errors     = 0;
    last_prod  = '0;
    Reset      = 1'b1;
    bus.Start  = 1'b0;
    bus.Hyrja0 = '0;
    bus.Hyrja1 = '0;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000_000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE_0001};
    vecs[2] = '{16'h0000, 16'h1234, 32'h0000_0000};
    vecs[3] = '{16'h8000, 16'h0002, 32'h0001_0000};
    vecs[4] = '{16'h0007, 16'h0009, 32'h0000_003F};
    vecs[5] = '{16'h0100, 16'h0100, 32'h0001_0000};

    #3;
    check("reset outputs", outs(), 32'd0);
    check("reset busy_done", {30'd0, bus.Busy, bus.Done}, 32'd0);
    tick();
    tick();
    Reset = 1'b0;
    tick();
    tick();
    check("idle no_done", {30'd0, bus.Busy, bus.Done}, 32'd0);

    // Directed table; the expected column is written out by hand.
    for (int i = 0; i < 6; i++) begin
      run_mul(vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      check($sformatf("vec%0d table", i), outs(), vecs[i].p);
      settle_idle($sformatf("vec%0d", i));
    end

    // Randomized operands, with every fourth one forced to an extreme.
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (i % 4 == 0) ra = 16'hFFFF;
      if (i % 8 == 1) rb = 16'h0000;
      run_mul(ra, rb, $sformatf("rand%0d", i));
      if (i % 3 == 0) tick();
      else settle_idle($sformatf("rand%0d", i));
    end

    // Start pulse during RUN is ignored: 7*9 must win over 2*2.
    bus.Hyrja0 = 16'd7;
    bus.Hyrja1 = 16'd9;
    bus.Start  = 1'b1;
    tick();
    bus.Start  = 1'b0;
    edges = 1;
    repeat (4) begin
      tick();
      edges++;
    end
    bus.Hyrja0 = 16'd2;
    bus.Hyrja1 = 16'd2;
    bus.Start  = 1'b1;
    tick();
    edges++;
    bus.Start  = 1'b0;
    while (!bus.Done && edges < 40) begin
      tick();
      edges++;
    end
    check("ignore latency", 32'(edges), 32'd17);
    check("ignore product", outs(), 32'h0000_003F);
    last_prod = 32'h0000_003F;
    dones = 0;
    repeat (20) begin
      tick();
      if (bus.Done) dones++;
    end
    check("ignore single_done", 32'(dones), 32'd0);
    check("ignore hold", outs(), 32'h0000_003F);

    // Back-to-back: Start high in the DONE cycle with new operands.
    run_mul(16'h1234, 16'h00FF, "b2b_first");
    bus.Hyrja0 = 16'h0100;
    bus.Hyrja1 = 16'h0100;
    bus.Start  = 1'b1;
    tick();
    bus.Start  = 1'b0;
    check("b2b busy_rise", {30'd0, bus.Busy, bus.Done}, 32'd2);
    check("b2b first_held", outs(), 32'h1234 * 32'hFF);
    edges = 1;
    while (!bus.Done && edges < 40) begin
      tick();
      edges++;
    end
    check("b2b second_latency", 32'(edges), 32'd17);
    check("b2b second_product", outs(), 32'h0001_0000);
    last_prod = 32'h0001_0000;
    settle_idle("b2b");

    // Asynchronous reset in the middle of RUN.
    bus.Hyrja0 = 16'h1234;
    bus.Hyrja1 = 16'h5678;
    bus.Start  = 1'b1;
    tick();
    bus.Start  = 1'b0;
    repeat (7) tick();
    check("midrst busy_before", 32'(bus.Busy), 32'd1);
    #2;
    Reset = 1'b1;
    #1;
    check("midrst outputs", outs(), 32'd0);
    check("midrst busy_done", {30'd0, bus.Busy, bus.Done}, 32'd0);
    tick();
    Reset = 1'b0;
    last_prod = '0;
    dones = 0;
    repeat (20) begin
      tick();
      if (bus.Done || bus.Busy) dones++;
    end
    check("midrst no_done", 32'(dones), 32'd0);
    run_mul(16'd3, 16'd5, "after_rst");
    settle_idle("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
